gnn_result_collector: RTL and testbench
=======================================

Name: gnn_result_collector

Overview:
- Host-side receiving end of the GNN `top` output interface.
- Drives the core's `in_ready` and watches the eight `out*_ready` flags. Each 21-bit result is latched the first cycle its flag is seen.
- Once all eight results are latched, they are streamed to the host one word per transfer over a valid/ready port.
- After streaming, `in_ready` is dropped for a fixed gap so the core restarts cleanly for the next inference.

Parameters:
- OUT_W, 21, width of each core result (signed).
- N_RES, 8, number of results per inference. Index k = node*2 + out.
- GAP_CYCLES, 5, cycles `core_in_ready` is held low between inferences (minimum 1).
- TIMEOUT, 64, maximum RUN cycles allowed to collect all flags before an error is declared.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  host pulse: inputs/weights to the core are stable, begin an inference.
- core_in_ready  out  1  drives the core's `in_ready`.
- res_ready  in  N_RES  core ready flags. Bit k = `out{k%2}_ready_node{k/2}`.
- res_data  in  N_RES*OUT_W  core results. Slice k = [k*OUT_W +: OUT_W], same k mapping as `res_ready`.
- m_valid  out  1  stream word valid.
- m_ready  in  1  host accepts the word.
- m_data  out  OUT_W  result word (signed, unmodified).
- m_index  out  3  k of the current word.
- m_last  out  1  high with k = N_RES-1.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky; cleared by the next accepted start.

Behaviour:
- Reset (async assert; release synchronous to clk):
  - state = IDLE.
  - core_in_ready = 0; m_valid = 0; m_data = 0; m_index = 0; m_last = 0; busy = 0; err_timeout = 0.
  - All capture registers and captured-flag bits = 0.
  - Reset asserted mid-operation aborts immediately; no partial stream is resumed.
- States: IDLE, RUN, DRAIN, GAP.
- IDLE:
  - start = 1 → RUN next cycle.
  - On entry to RUN: clear the captured mask and err_timeout, zero the timeout counter, set core_in_ready = 1 (registered).
  - start while not IDLE is ignored.
- RUN:
  - Each cycle, for every k with res_ready[k] = 1 and captured[k] = 0: latch slice k and set captured[k].
  - Once captured[k] is set, later changes of res_ready[k] or its slice are ignored.
  - When the captured mask is all ones (including the cycle the last flag is latched), go to DRAIN next cycle with index 0.
  - The timeout counter increments each RUN cycle. If it reaches TIMEOUT with the mask incomplete: set err_timeout, go to GAP, emit no stream words.
- DRAIN:
  - core_in_ready stays 1 so the core holds its outputs.
  - m_valid = 1; m_data = captured[index]; m_last = (index == N_RES-1).
  - Transfer occurs when m_valid && m_ready; index then increments.
  - m_data, m_index and m_last must stay stable while m_valid && !m_ready.
  - Transfer with m_last → m_valid = 0 next cycle, go to GAP.
- GAP:
  - core_in_ready = 0 for exactly GAP_CYCLES cycles (counter), then IDLE.
  - start during GAP is ignored; the host must re-issue it in IDLE.
- Latency: start on cycle t → core_in_ready high at t+1. Flags all high at cycle u → first m_valid at u+1.
- Width: data is passed through bit-exact. No sign extension or saturation.

Test Plan:
- Nominal: start pulse; all eight flags rise 4 cycles later with res_data slice k = k*100 − 350; m_ready = 1 → eight words −350, −250, …, 350 on consecutive cycles with m_index 0..7, m_last only on index 7; core_in_ready then 0 for exactly 5 cycles; busy drops on the IDLE cycle.
- Staggered flags: flag k rises at cycle 2+k. Each slice changes to 21'h0FFFFF one cycle after its flag rises → captured values equal the pre-change data. Stream starts the cycle after flag 7.
- Backpressure: m_ready low for 3 cycles on index 2 and again on index 7 → words held stable with no duplicates or drops; exactly 8 transfers.
- Extremes: slices alternate 21'h0FFFFF (1048575) and 21'h100000 (−1048576) → output bit-exact, sign preserved.
- Timeout: start with flag 5 never asserted and TIMEOUT = 64 → err_timeout set after 64 RUN cycles, no m_valid, 5-cycle GAP, IDLE. Next start clears err_timeout and completes normally.
- Reset mid-DRAIN: assert rst_n low during index 3 → outputs return to reset values immediately. After release, a new start produces a full, correct 8-word stream.

Source files
------------

// File: rtl/gnn_result_collector.sv
// Host-side collector for the GNN core outputs: latches each result on its first ready flag,
// streams the full set over a valid/ready port, then idles the core for a fixed gap.
module gnn_result_collector #(
   parameter int unsigned OUT_W      = 21,
   parameter int unsigned N_RES      = 8,
   parameter int unsigned GAP_CYCLES = 5,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   core_in_ready,
   input  logic [N_RES-1:0]       res_ready,
   input  logic [N_RES*OUT_W-1:0] res_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [OUT_W-1:0]       m_data,
   output logic [2:0]             m_index,
   output logic                   m_last,
   output logic                   busy,
   output logic                   err_timeout
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
   localparam logic [TW-1:0] TO_VAL   = TW'(TIMEOUT);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [2:0]    LAST_IDX = 3'(N_RES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StGap
   } state_e;

   state_e                 state_q, state_d;
   logic                   cir_q, cir_d;
   logic                   err_q, err_d;
   logic [N_RES-1:0]       mask_q, mask_d;
   logic [OUT_W-1:0]       cap_q [N_RES];
   logic [OUT_W-1:0]       cap_d [N_RES];
   logic [2:0]             idx_q, idx_d;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic [GW-1:0]          gcnt_q, gcnt_d;

   always_comb begin
      state_d = state_q;
      cir_d   = cir_q;
      err_d   = err_q;
      mask_d  = mask_q;
      cap_d   = cap_q;
      idx_d   = idx_q;
      tcnt_d  = tcnt_q;
      gcnt_d  = gcnt_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               cir_d   = 1'b1;
               err_d   = 1'b0;
               mask_d  = '0;
               tcnt_d  = '0;
            end
         end

         StRun: begin
            // First sighting of each flag wins; later flag/data changes are ignored.
            for (int unsigned k = 0; k < N_RES; k++) begin
               if (res_ready[k] && !mask_q[k]) begin
                  cap_d[k]  = res_data[k*OUT_W +: OUT_W];
                  mask_d[k] = 1'b1;
               end
            end
            tcnt_d = tcnt_q + 1'b1;
            if (&mask_d) begin
               state_d = StDrain;
               idx_d   = '0;
            end else if (tcnt_d == TO_VAL) begin
               state_d = StGap;
               err_d   = 1'b1;
               cir_d   = 1'b0;
               gcnt_d  = '0;
            end
         end

         StDrain: begin
            if (m_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = StGap;
                  cir_d   = 1'b0;
                  gcnt_d  = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         StGap: begin
            gcnt_d = gcnt_q + 1'b1;
            if (gcnt_q == GAP_LAST) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
            cir_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cir_q   <= 1'b0;
         err_q   <= 1'b0;
         mask_q  <= '0;
         idx_q   <= '0;
         tcnt_q  <= '0;
         gcnt_q  <= '0;
         for (int unsigned k = 0; k < N_RES; k++) begin
            cap_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         cir_q   <= cir_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
         tcnt_q  <= tcnt_d;
         gcnt_q  <= gcnt_d;
         cap_q   <= cap_d;
      end
   end

   // Stream outputs decode straight from registered state, so reset clears them at once.
   always_comb begin
      m_valid       = (state_q == StDrain);
      m_data        = m_valid ? cap_q[idx_q] : '0;
      m_index       = m_valid ? idx_q : '0;
      m_last        = m_valid && (idx_q == LAST_IDX);
      busy          = (state_q != StIdle);
      core_in_ready = cir_q;
      err_timeout   = err_q;
   end

endmodule

// File: tb/tb_gnn_result_collector.sv
// Randomised scoreboard bench for gnn_result_collector: expected words are queued when an
// inference is launched and a monitor pops them on every stream transfer.
module tb_gnn_result_collector;

   localparam int OUT_W = 21;
   localparam int N_RES = 8;
   localparam int GAP   = 5;
   localparam int TMO   = 64;
   localparam int NEVER = 100000;

   logic                   clk;
   logic                   rst_n;
   logic                   start;
   logic                   core_in_ready;
   logic [N_RES-1:0]       res_ready;
   logic [N_RES*OUT_W-1:0] res_data;
   logic                   m_valid;
   logic                   m_ready;
   logic [OUT_W-1:0]       m_data;
   logic [2:0]             m_index;
   logic                   m_last;
   logic                   busy;
   logic                   err_timeout;

   gnn_result_collector #(
      .OUT_W(OUT_W),
      .N_RES(N_RES),
      .GAP_CYCLES(GAP),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .core_in_ready(core_in_ready),
      .res_ready(res_ready),
      .res_data(res_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data(m_data),
      .m_index(m_index),
      .m_last(m_last),
      .busy(busy),
      .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [OUT_W-1:0] d;
      logic [2:0]       i;
      logic             l;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          xfers    = 0;
   int          bp_mode  = 0;
   logic [OUT_W-1:0] cur_vals [N_RES];
   int          cur_rise [N_RES];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference data schedule: scrambled before the flag, the real value on the rising cycle,
   // optionally overwritten afterwards.
   function automatic logic [OUT_W-1:0] data_at(input int k, input int c, input int chg);
      if (c < cur_rise[k]) return cur_vals[k] ^ 21'h15555;
      if (chg != 0 && c > cur_rise[k]) return 21'h0FFFFF;
      return cur_vals[k];
   endfunction

   // Host backpressure: 0 = always ready, 1 = 3-cycle stall on index 2 and 7, 2 = random.
   initial begin
      int stall;
      stall   = 0;
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            1: begin
               if (m_valid && (m_index == 3'd2 || m_index == 3'd7)) begin
                  if (stall < 3) begin
                     m_ready = 1'b0;
                     stall++;
                  end else begin
                     m_ready = 1'b1;
                  end
               end else begin
                  stall   = 0;
                  m_ready = 1'b1;
               end
            end
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
         endcase
      end
   end

   // Monitor: pops the scoreboard on each transfer and checks hold-stability under stall.
   initial begin
      logic             prev_stall;
      logic [OUT_W-1:0] prev_data;
      logic [2:0]       prev_idx;
      exp_t             e;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_idx   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", 32'(m_valid), 32'd1);
               chk("hold_data", 32'(m_data), 32'(prev_data));
               chk("hold_index", 32'(m_index), 32'(prev_idx));
            end
            if (m_valid && m_ready) begin
               xfers++;
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_word: got index %0d data 0x%0h, expected none",
                           m_index, m_data);
               end else begin
                  e = sb.pop_front();
                  chk("word_data", 32'(m_data), 32'(e.d));
                  chk("word_index", 32'(m_index), 32'(e.i));
                  chk("word_last", 32'(m_last), 32'(e.l));
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_idx   = m_index;
         end
      end
   end

   // One inference: chg overwrites data after each flag, stray pulses start during GAP,
   // rst3 asserts reset when index 3 is presented.
   task automatic run_inf(input int chg, input int stray, input int rst3);
      int  maxr, first_v, gap, run_c, x0, c;
      bit  done, complete;
      maxr = 0;
      for (int k = 0; k < N_RES; k++) if (cur_rise[k] > maxr) maxr = cur_rise[k];
      complete = (maxr <= TMO);
      if (complete) begin
         for (int k = 0; k < N_RES; k++) begin
            sb.push_back('{d: cur_vals[k], i: 3'(k), l: (k == N_RES - 1)});
         end
      end
      first_v = -1;
      gap     = 0;
      run_c   = 0;
      done    = 1'b0;
      x0      = xfers;
      for (c = 0; c < 300 && !done; c++) begin
         start = (c == 0) || (stray != 0 && gap > 0 && gap < 3);
         for (int k = 0; k < N_RES; k++) begin
            res_ready[k]               = (c >= cur_rise[k]);
            res_data[k*OUT_W +: OUT_W] = data_at(k, c, chg);
         end
         @(negedge clk);
         if (c == 1) begin
            chk("cir_latency", 32'(core_in_ready), 32'd1);
            chk("err_cleared", 32'(err_timeout), 32'd0);
         end
         if (m_valid && first_v < 0) first_v = c;
         if (busy && !core_in_ready) gap++;
         if (busy && core_in_ready && !m_valid) run_c++;
         if (c > 0 && !busy) done = 1'b1;
         @(posedge clk);
         #1;
         if (rst3 != 0 && m_valid && m_index == 3'd3) begin
            rst_n = 1'b0;
            #1;
            chk("rst_m_valid", 32'(m_valid), 32'd0);
            chk("rst_m_data", 32'(m_data), 32'd0);
            chk("rst_m_index", 32'(m_index), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_cir", 32'(core_in_ready), 32'd0);
            chk("rst_xfers", 32'(xfers - x0), 32'd3);
            sb.delete();
            res_ready = '0;
            res_data  = '0;
            start     = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            return;
         end
      end
      start     = 1'b0;
      res_ready = '0;
      res_data  = '0;
      chk("finished_in_bound", 32'(done), 32'd1);
      chk("gap_cycles", 32'(gap), 32'(GAP));
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("xfer_count", 32'(xfers - x0), complete ? 32'd8 : 32'd0);
      chk("err_timeout", 32'(err_timeout), complete ? 32'd0 : 32'd1);
      if (complete) chk("first_valid", 32'(first_v), 32'(maxr + 1));
      else chk("run_cycles", 32'(run_c), 32'(TMO));
      sb.delete();
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      res_ready = '0;
      res_data  = '0;
      repeat (3) @(negedge clk);
      chk("reset_cir", 32'(core_in_ready), 32'd0);
      chk("reset_m_valid", 32'(m_valid), 32'd0);
      chk("reset_m_data", 32'(m_data), 32'd0);
      chk("reset_m_index", 32'(m_index), 32'd0);
      chk("reset_m_last", 32'(m_last), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_err", 32'(err_timeout), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Nominal: all flags at cycle 4, data k*100-350.
      for (int k = 0; k < N_RES; k++) begin
         cur_vals[k] = 21'(k * 100 - 350);
         cur_rise[k] = 4;
      end
      bp_mode = 0;
      run_inf(0, 0, 0);

      // Staggered flags with post-flag data change, plus a stray start during GAP.
      for (int k = 0; k < N_RES; k++) begin
         cur_vals[k] = 21'($urandom);
         cur_rise[k] = 2 + k;
      end
      run_inf(1, 1, 0);

      // Backpressure on index 2 and 7.
      for (int k = 0; k < N_RES; k++) begin
         cur_vals[k] = 21'($urandom);
         cur_rise[k] = 3;
      end
      bp_mode = 1;
      run_inf(0, 0, 0);

      // Extremes: alternating max positive / max negative.
      for (int k = 0; k < N_RES; k++) begin
         cur_vals[k] = (k % 2 == 0) ? 21'h0FFFFF : 21'h100000;
         cur_rise[k] = 2;
      end
      bp_mode = 0;
      run_inf(0, 0, 0);

      // Timeout: flag 5 never rises, then a normal run clears the error.
      for (int k = 0; k < N_RES; k++) begin
         cur_vals[k] = 21'($urandom);
         cur_rise[k] = (k == 5) ? NEVER : 4;
      end
      run_inf(0, 0, 0);
      cur_rise[5] = 6;
      run_inf(1, 0, 0);

      // Reset while index 3 is presented, then a full run.
      for (int k = 0; k < N_RES; k++) begin
         cur_vals[k] = 21'($urandom);
         cur_rise[k] = 3;
      end
      run_inf(0, 0, 1);
      run_inf(0, 0, 0);

      // Random flags, data and backpressure.
      bp_mode = 2;
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < N_RES; k++) begin
            cur_vals[k] = 21'($urandom);
            cur_rise[k] = 2 + int'($urandom_range(0, 12));
         end
         run_inf(int'($urandom_range(0, 1)), 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
